sc_chain_prbs_checker: RTL and testbench



---
 rtl/sc_test_pkg.sv | 14 +
 rtl/sc_sat_counter.sv | 21 ++
 rtl/sc_chain_prbs_checker.sv | 140 ++++++++++++++
 tb/tb_sc_chain_prbs_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_test_pkg.sv
// Shared definitions for the test-die shift-chain PRBS7 source and checker.
package sc_test_pkg;

  typedef enum logic {
    SEED,
    CHECK
  } sc_state_e;

  // x^7 + x^6 + 1: the next bit is lfsr[6] ^ lfsr[5], shifted in at the LSB.
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;
  localparam int PRBS7_LEN   = 7;

endpackage

// File: rtl/sc_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sc_sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      Q <= '0;
    end else if (INC && (Q != '1)) begin
      Q <= Q + 1'b1;
    end
  end

endmodule

// File: rtl/sc_chain_prbs_checker.sv
// PRBS7 checker at the output of the test-die shift chain: self-seeds, checks,
// counts bits and errors, and re-seeds when too many errors land in one window.
module sc_chain_prbs_checker
  import sc_test_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VPW,
  input  logic             VNW,
  input  logic             VDD,
  input  logic             VSS,
  input  logic             EN,
  input  logic             DIN,
  input  logic             CLR,
  output logic             LOCKED,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] BIT_CNT
);

  localparam int WC_W = $clog2(WIN + 1);
  localparam int WE_W = $clog2(LOSS_THR + 1);

  sc_state_e            state, state_nxt;
  logic [PRBS7_LEN-1:0] lfsr, lfsr_nxt;
  logic [2:0]           seed_cnt, seed_cnt_nxt;
  logic [WC_W-1:0]      win_cnt, win_cnt_nxt;
  logic [WE_W-1:0]      win_err, win_err_nxt;
  logic [WE_W:0]        err_sum;
  logic                 exp_bit, mis, err_nxt, bit_inc, err_inc;

  // Bias/power pins carry no logic; fold them into a sink so they are visibly consumed.
  logic unused_pwr;
  assign unused_pwr = ^{VPW, VNW, VDD, VSS};

  assign exp_bit = lfsr[PRBS7_TAP_A] ^ lfsr[PRBS7_TAP_B];
  assign mis     = DIN ^ exp_bit;
  assign err_sum = {1'b0, win_err} + (WE_W + 1)'(mis);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    lfsr_nxt     = lfsr;
    seed_cnt_nxt = seed_cnt;
    win_cnt_nxt  = win_cnt;
    win_err_nxt  = win_err;
    err_nxt      = 1'b0;
    bit_inc      = 1'b0;
    err_inc      = 1'b0;

    if (EN) begin
      unique case (state)
        SEED: begin
          lfsr_nxt = {lfsr[PRBS7_LEN-2:0], DIN};
          if (seed_cnt == 3'(PRBS7_LEN - 1)) begin
            state_nxt    = CHECK;
            seed_cnt_nxt = '0;
          end else begin
            seed_cnt_nxt = seed_cnt + 3'd1;
          end
        end
        CHECK: begin
          if (lfsr == '0) begin
            // A zero register would predict zeros forever; throw it away and re-seed.
            state_nxt    = SEED;
            seed_cnt_nxt = '0;
            win_cnt_nxt  = '0;
            win_err_nxt  = '0;
          end else begin
            // The reference free-runs on its own prediction, so a bad DIN bit cannot corrupt it.
            lfsr_nxt = {lfsr[PRBS7_LEN-2:0], exp_bit};
            err_nxt  = mis;
            bit_inc  = 1'b1;
            err_inc  = mis;
            if (err_sum >= (WE_W + 1)'(LOSS_THR)) begin
              state_nxt    = SEED;
              seed_cnt_nxt = '0;
              win_cnt_nxt  = '0;
              win_err_nxt  = '0;
            end else if (win_cnt == WC_W'(WIN - 1)) begin
              win_cnt_nxt = '0;
              win_err_nxt = '0;
            end else begin
              win_cnt_nxt = win_cnt + 1'b1;
              win_err_nxt = err_sum[WE_W-1:0];
            end
          end
        end
        default: state_nxt = SEED;
      endcase
    end

    // Clear is applied after the loss-of-lock decision, so a same-edge re-seed still happens.
    if (CLR) begin
      win_cnt_nxt = '0;
      win_err_nxt = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= SEED;
      lfsr     <= '0;
      seed_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_nxt;
      seed_cnt <= seed_cnt_nxt;
      win_cnt  <= win_cnt_nxt;
      win_err  <= win_err_nxt;
      ERR      <= err_nxt;
    end
  end

  assign LOCKED = (state == CHECK);

  sc_sat_counter #(.W(CNT_W)) u_bit_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .INC (bit_inc),
    .Q   (BIT_CNT)
  );

  sc_sat_counter #(.W(CNT_W)) u_err_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .INC (err_inc),
    .Q   (ERR_CNT)
  );

endmodule

// File: tb/tb_sc_chain_prbs_checker.sv
// Directed bench for sc_chain_prbs_checker: a 16-bit-counter instance and a
// 4-bit-counter instance share one stimulus stream.
module tb_sc_chain_prbs_checker;

  logic        CLK, RST, EN, DIN, CLR;
  logic        pwr_hi, pwr_lo;
  logic        locked, err, s_locked, s_err;
  logic [15:0] err_cnt, bit_cnt;
  logic [3:0]  s_err_cnt, s_bit_cnt;

  int          checks, errors;
  int          err_pulses, gap_err;
  logic [6:0]  g;

  assign pwr_hi = 1'b1;
  assign pwr_lo = 1'b0;

  sc_chain_prbs_checker #(.CNT_W(16), .WIN(64), .LOSS_THR(8)) u_dut (
    .CLK(CLK), .RST(RST), .VPW(pwr_hi), .VNW(pwr_lo), .VDD(pwr_hi), .VSS(pwr_lo),
    .EN(EN), .DIN(DIN), .CLR(CLR),
    .LOCKED(locked), .ERR(err), .ERR_CNT(err_cnt), .BIT_CNT(bit_cnt)
  );

  sc_chain_prbs_checker #(.CNT_W(4), .WIN(64), .LOSS_THR(8)) u_dut_s (
    .CLK(CLK), .RST(RST), .VPW(pwr_hi), .VNW(pwr_lo), .VDD(pwr_hi), .VSS(pwr_lo),
    .EN(EN), .DIN(DIN), .CLR(CLR),
    .LOCKED(s_locked), .ERR(s_err), .ERR_CNT(s_err_cnt), .BIT_CNT(s_bit_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic cycle(input logic en, input logic din, input logic clr, input logic rst);
    EN  = en;
    DIN = din;
    CLR = clr;
    RST = rst;
    @(posedge CLK);
    #1;
    if (err) err_pulses++;
    if (!en && err) gap_err++;
    EN  = 1'b0;
    CLR = 1'b0;
    RST = 1'b0;
  endtask

  // Reference source: s[n] = s[n-7] ^ s[n-6], emitted MSB first from seed g.
  task automatic next_prbs(output logic b);
    b = g[6];
    g = {g[5:0], g[6] ^ g[5]};
  endtask

  task automatic send_prbs(input logic flip);
    logic b;
    next_prbs(b);
    cycle(1'b1, b ^ flip, 1'b0, 1'b0);
  endtask

  task automatic relock(input string tag);
    for (int j = 1; j <= 7; j++) begin
      send_prbs(1'b0);
      if (j == 6) check({tag, "_not_yet"}, locked, 0);
      if (j == 7) check({tag, "_locked"}, locked, 1);
    end
  endtask

  initial begin
    checks = 0; errors = 0; err_pulses = 0; gap_err = 0;
    RST = 1'b0; EN = 1'b0; DIN = 1'b0; CLR = 1'b0;
    g = 7'h7F;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_bit_cnt", bit_cnt, 0);

    // Clean lock: 200 bits from seed 7F
    err_pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      send_prbs(1'b0);
      if (i == 6) check("clean_lock_bit6", locked, 0);
      if (i == 7) check("clean_lock_bit7", locked, 1);
    end
    check("clean_err_pulses", err_pulses, 0);
    check("clean_bit_cnt", bit_cnt, 193);
    check("clean_err_cnt", err_cnt, 0);

    // Single error at bit 50 after a clear, followed by an EN=0 gap
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_bit_cnt", bit_cnt, 0);
    check("clr_locked", locked, 1);
    err_pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      send_prbs(i == 50);
      if (i == 49) check("single_no_early_err", err, 0);
      if (i == 50) begin
        check("single_err_pulse", err, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("single_err_drops_gap", err, 0);
      end
    end
    check("single_err_pulses", err_pulses, 1);
    check("single_err_cnt", err_cnt, 1);
    check("single_bit_cnt", bit_cnt, 60);
    check("single_locked", locked, 1);

    // Window rollover: 7 errors, window wraps after bit 64, 7 more errors
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 71; i++) send_prbs((i <= 7) || (i >= 65));
    check("win_roll_locked", locked, 1);
    check("win_roll_err_cnt", err_cnt, 14);

    // Loss of lock: 8 flips within 15 bits
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      send_prbs(i % 2 == 1);
      if (i == 13) check("lol_after_7th", locked, 1);
      if (i == 15) begin
        check("lol_on_8th", locked, 0);
        check("lol_err_8th", err, 1);
      end
    end
    relock("lol_relock");
    check("lol_err_cnt_kept", err_cnt, 8);
    check("lol_bit_cnt_kept", bit_cnt, 15);
    err_pulses = 0;
    for (int i = 1; i <= 20; i++) send_prbs(1'b0);
    check("lol_post_err_pulses", err_pulses, 0);
    check("lol_post_bit_cnt", bit_cnt, 35);

    // EN gaps: pattern 1,0,0,1 with junk DIN on idle cycles
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    g = 7'h7F; err_pulses = 0; gap_err = 0;
    begin
      int nbits;
      nbits = 0;
      for (int c = 0; nbits < 100; c++) begin
        if ((c % 4 == 0) || (c % 4 == 3)) begin
          send_prbs(1'b0);
          nbits++;
          if (nbits == 7) check("gap_lock_bit7", locked, 1);
        end else begin
          cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
      end
    end
    check("gap_err_pulses", err_pulses, 0);
    check("gap_err_on_idle", gap_err, 0);
    check("gap_bit_cnt", bit_cnt, 93);
    check("gap_err_cnt", err_cnt, 0);

    // All-zero trap: seeding with zeros locks, then re-seeds on the next bit
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("trap_locked", locked, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("trap_reseed", locked, 0);
    check("trap_err", err, 0);

    // Saturation with all-ones DIN: 7 seed + 9 check bits (8 errors) per lock episode
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 7)  check("ones_lock", s_locked, 1);
      if (i == 16) begin
        check("ones_first_loss", s_locked, 0);
        check("ones_first_err_cnt", s_err_cnt, 8);
      end
    end
    check("sat_err_cnt", s_err_cnt, 15);
    check("sat_bit_cnt", s_bit_cnt, 15);
    check("wide_err_cnt", err_cnt, 16);
    check("wide_bit_cnt", bit_cnt, 18);
    for (int i = 1; i <= 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("sat_relock", s_locked, 1);
    check("sat_err_cnt_held", s_err_cnt, 15);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_mis_err", s_err, 1);
    check("clr_mis_err_cnt", s_err_cnt, 0);
    check("clr_mis_bit_cnt", s_bit_cnt, 0);
    check("clr_mis_locked", s_locked, 1);

    // Reset in the middle of checking, at bit 100
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    g = 7'h7F;
    for (int i = 1; i <= 99; i++) send_prbs(1'b0);
    check("mid_pre_bit_cnt", bit_cnt, 92);
    begin
      logic b;
      next_prbs(b);
      cycle(1'b1, b, 1'b0, 1'b1);
    end
    check("mid_rst_locked", locked, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_bit_cnt", bit_cnt, 0);
    relock("mid_relock");
    err_pulses = 0;
    for (int i = 1; i <= 20; i++) send_prbs(1'b0);
    check("mid_post_err_pulses", err_pulses, 0);
    check("mid_post_bit_cnt", bit_cnt, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
